wb_dbg_bridge: RTL

Byte-stream-to-Wishbone master that lets a host drive the SoC bus over the serial link. It consumes received bytes from the UART receive path, decodes single-word read/write commands, and issues classic Wishbone cycles as a second bus master ahead of the bus mux/arbiter. It returns status and read data as bytes on the UART transmit path. Its uses are firmware loading into RAM and peripheral debug without CPU involvement.

---
 rtl/wb_dbg_pkg.sv | 9 +
 rtl/wb_dbg_bridge.sv | 114 +++++++++++
 2 files changed

// File: rtl/wb_dbg_pkg.sv
// wb_dbg_pkg: command/status codes and FSM states shared by the debug bridge.
package wb_dbg_pkg;
    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] ST_OK      = 8'hA5;
    localparam logic [7:0] ST_TIMEOUT = 8'hEE;
    localparam logic [7:0] ST_BADCMD  = 8'hE1;
    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;
endpackage

// File: rtl/wb_dbg_bridge.sv
// wb_dbg_bridge: decodes UART byte commands into single Wishbone read/write cycles
// and streams the status plus read data back as bytes.
module wb_dbg_bridge
    import wb_dbg_pkg::*;
#(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int ACK_TIMEOUT   = 255,
    parameter int RX_TIMEOUT    = 100000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [7:0]               rx_data_i,
    input  logic                     rx_valid_i,
    output logic [7:0]               tx_data_o,
    output logic                     tx_valid_o,
    input  logic                     tx_ready_i,
    output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    output logic                     wb_we_o,
    output logic [3:0]               wb_sel_o,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    input  logic                     wb_ack_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
    output logic                     busy_o,
    output logic                     rx_overrun_o
);
    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
    localparam int RX_W  = $clog2(RX_TIMEOUT + 1);

    state_t                   state, state_n;
    logic [1:0]               bcnt;
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0] dat;
    logic                     is_read;
    logic [ACK_W-1:0]         acnt;
    logic [RX_W-1:0]          rcnt;
    logic [2:0]               tx_left;
    logic                     tx_fire, ack_to, rx_to, rx_phase;

    assign tx_fire   = tx_valid_o && tx_ready_i;
    assign ack_to    = acnt == ACK_W'(ACK_TIMEOUT);
    assign rx_to     = rcnt == RX_W'(RX_TIMEOUT - 1);
    assign rx_phase  = state == ADDR || state == DATA;
    assign wb_addr_o = addr & ~WB_ADDR_WIDTH'(3);
    assign wb_data_o = dat;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (rx_valid_i) state_n = (rx_data_i == CMD_WRITE || rx_data_i == CMD_READ) ? ADDR : RESP;
            ADDR: if (rx_valid_i && bcnt == 2'd3) state_n = is_read ? BUS : DATA;
                  else if (!rx_valid_i && rx_to) state_n = IDLE;
            DATA: if (rx_valid_i && bcnt == 2'd3) state_n = BUS;
                  else if (!rx_valid_i && rx_to) state_n = IDLE;
            BUS:  if (wb_ack_i || ack_to) state_n = RESP;
            RESP: if (tx_fire && tx_left == 3'd0) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            bcnt         <= '0;
            addr         <= '0;
            dat          <= '0;
            is_read      <= 1'b0;
            acnt         <= '0;
            rcnt         <= '0;
            tx_left      <= '0;
            tx_data_o    <= '0;
            tx_valid_o   <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_sel_o     <= '0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            busy_o       <= 1'b0;
            rx_overrun_o <= 1'b0;
        end else begin
            state        <= state_n;
            rx_overrun_o <= rx_valid_i && (state == BUS || state == RESP);
            rcnt         <= (rx_valid_i || !rx_phase) ? '0 : rcnt + 1'b1;
            acnt         <= (state == BUS) ? acnt + 1'b1 : '0;
            bcnt         <= (state_n == IDLE) ? 2'd0 : (rx_valid_i && rx_phase) ? bcnt + 2'd1 : bcnt;
            if (state == IDLE && rx_valid_i)
                is_read <= rx_data_i == CMD_READ;
            if (state == ADDR && rx_valid_i)
                addr <= {rx_data_i, addr[WB_ADDR_WIDTH-1:8]};
            // dat doubles as write-data shifter, read-data latch and tx shifter
            if (state == DATA && rx_valid_i)
                dat <= {rx_data_i, dat[WB_DATA_WIDTH-1:8]};
            else if (state == BUS && wb_ack_i)
                dat <= wb_data_i;
            else if (state == RESP && tx_fire)
                dat <= {8'h00, dat[WB_DATA_WIDTH-1:8]};
            wb_cyc_o <= state_n == BUS;
            wb_stb_o <= state_n == BUS;
            wb_we_o  <= state_n == BUS && !is_read;
            wb_sel_o <= (state_n == BUS) ? 4'hF : 4'h0;
            busy_o   <= state_n != IDLE;
            if (state_n == RESP && state != RESP) begin
                tx_valid_o <= 1'b1;
                tx_data_o  <= (state == IDLE) ? ST_BADCMD : wb_ack_i ? ST_OK : ST_TIMEOUT;
                tx_left    <= (state == BUS && wb_ack_i && is_read) ? 3'd4 : 3'd0;
            end else if (tx_fire) begin
                tx_valid_o <= tx_left != 3'd0;
                tx_data_o  <= dat[7:0];
                tx_left    <= (tx_left != 3'd0) ? tx_left - 3'd1 : 3'd0;
            end
        end
    end
endmodule
